// File: rtl/mmio_port_bank.sv
// mmio_port_bank: memory-mapped I/O window of NUM_PORTS channels between the
// processor data bus and data memory.
//
// Each channel occupies two addresses starting at BASE_ADDR + 2*ch:
//   even (DATA): read = synchronised port_in[ch], write = port_out[ch]
//   odd  (CTRL): read = {0.., ien, flag}; write bit1 -> ien, bit0=1 clears flag
// The bank owns the read-data mux (I/O vs memory) and blocks memory writes
// that land inside the window.
//
// Ports:
//   clk, reset        rising-edge clock, asynchronous active-high reset
//   addr, wdata, we   processor bus address / write data / write strobe
//   mem_rdata         data-memory read data
//   rdata             read data returned to the core
//   mem_we            write strobe forwarded to data memory (we && !hit)
//   hit               addr lies inside the I/O window
//   port_in           external inputs, channel i at [i*DATA_WIDTH +: DATA_WIDTH],
//                     asynchronous to clk
//   port_out          registered external outputs, same packing
//   irq               OR of enabled sticky change flags
//
// BASE_ADDR must be even and BASE_ADDR + 2*NUM_PORTS <= 2**ADDR_WIDTH.

// Per-channel state: output latch, two-flop synchroniser, previous-sample
// register for change detection, sticky flag and interrupt enable.
module mmio_port_bank_chan #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] port_in,
  input  logic                  data_we,
  input  logic                  ctrl_we,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] port_out,
  output logic [DATA_WIDTH-1:0] din_sync,
  output logic                  flag,
  output logic                  ien
);
  logic [DATA_WIDTH-1:0] s1, s2, prev;
  logic                  chg, clr;

  assign chg      = (s2 != prev);
  assign clr      = ctrl_we & wdata[0];
  assign din_sync = s2;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1       <= '0;
      s2       <= '0;
      prev     <= '0;
      port_out <= '0;
      flag     <= 1'b0;
      ien      <= 1'b0;
    end else begin
      s1   <= port_in;
      s2   <= s1;
      prev <= s2;
      if (data_we) port_out <= wdata;
      if (ctrl_we) ien      <= wdata[1];
      // A change seen on the same edge as a clear keeps the flag set so no
      // event is lost.
      flag <= chg | (flag & ~clr);
    end
  end
endmodule

module mmio_port_bank #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8,
  parameter int NUM_PORTS  = 4,
  parameter int BASE_ADDR  = 240
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [ADDR_WIDTH-1:0]           addr,
  input  logic [DATA_WIDTH-1:0]           wdata,
  input  logic                            we,
  input  logic [DATA_WIDTH-1:0]           mem_rdata,
  output logic [DATA_WIDTH-1:0]           rdata,
  output logic                            mem_we,
  output logic                            hit,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0] port_in,
  output logic [NUM_PORTS*DATA_WIDTH-1:0] port_out,
  output logic                            irq
);
  localparam int WIN_END = BASE_ADDR + 2*NUM_PORTS;

  logic [NUM_PORTS-1:0][DATA_WIDTH-1:0] pin_a, pout_a, din_a, ctrl_a;
  logic [NUM_PORTS-1:0]                 ch_sel, flag_a, ien_a;
  logic [ADDR_WIDTH:0]                  addr_x;
  logic [ADDR_WIDTH-1:0]                off;
  logic [DATA_WIDTH-1:0]                io_read;

  // One extra address bit so a window ending exactly at 2**ADDR_WIDTH
  // still compares correctly.
  assign addr_x = {1'b0, addr};
  assign hit    = (addr_x >= (ADDR_WIDTH+1)'(BASE_ADDR)) &&
                  (addr_x <  (ADDR_WIDTH+1)'(WIN_END));
  assign off    = addr - ADDR_WIDTH'(BASE_ADDR);
  assign mem_we = we & ~hit;

  assign pin_a    = port_in;
  assign port_out = pout_a;

  for (genvar i = 0; i < NUM_PORTS; i++) begin : g_ch
    assign ch_sel[i] = hit && (off[ADDR_WIDTH-1:1] == (ADDR_WIDTH-1)'(i));
    assign ctrl_a[i] = {{(DATA_WIDTH-2){1'b0}}, ien_a[i], flag_a[i]};

    mmio_port_bank_chan #(.DATA_WIDTH(DATA_WIDTH)) u_chan (
      .clk      (clk),
      .reset    (reset),
      .port_in  (pin_a[i]),
      .data_we  (we & ch_sel[i] & ~off[0]),
      .ctrl_we  (we & ch_sel[i] &  off[0]),
      .wdata    (wdata),
      .port_out (pout_a[i]),
      .din_sync (din_a[i]),
      .flag     (flag_a[i]),
      .ien      (ien_a[i])
    );
  end

  // ch_sel is one-hot (or zero when outside the window).
  always_comb begin
    io_read = '0;
    for (int i = 0; i < NUM_PORTS; i++)
      if (ch_sel[i]) io_read = off[0] ? ctrl_a[i] : din_a[i];
  end

  assign rdata = hit ? io_read : mem_rdata;
  assign irq   = |(flag_a & ien_a);
endmodule

// File: tb/tb_mmio_port_bank.sv
module tb_mmio_port_bank;
  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  addr, wdata, mem_rdata, rdata;
  logic        we, mem_we, hit, irq;
  logic [31:0] port_in, port_out;

  int n_tests = 0;
  int n_fail  = 0;

  mmio_port_bank #(.DATA_WIDTH(8), .ADDR_WIDTH(8), .NUM_PORTS(4), .BASE_ADDR(240)) dut (
    .clk(clk), .reset(reset), .addr(addr), .wdata(wdata), .we(we),
    .mem_rdata(mem_rdata), .rdata(rdata), .mem_we(mem_we), .hit(hit),
    .port_in(port_in), .port_out(port_out), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic bus_write(input logic [7:0] a, input logic [7:0] d);
    addr = a; wdata = d; we = 1'b1;
    tick();
    we = 1'b0;
  endtask

  task automatic set_port(input int ch, input logic [7:0] v);
    port_in[ch*8 +: 8] = v;
  endtask

  task automatic test_reset;
    reset = 1'b1; we = 1'b0; addr = 8'd0; wdata = 8'd0; mem_rdata = 8'h00;
    port_in = 32'hA5A5_A5A5;
    #3;
    tick(); tick();
    n_tests++; if (port_out !== 32'h0) begin n_fail++; $display("FAIL reset_port_out: got %h want %h", port_out, 32'h0); end
    n_tests++; if (irq !== 1'b0) begin n_fail++; $display("FAIL reset_irq: got %b want 0", irq); end
    addr = 8'd241; #1;
    n_tests++; if (rdata !== 8'h00) begin n_fail++; $display("FAIL reset_ctrl_read: got %h want 00", rdata); end
    addr = 8'd240;
    reset = 1'b0;
    tick(); // edge 1: s1 = A5
    n_tests++; if (rdata !== 8'h00) begin n_fail++; $display("FAIL sync_edge1: got %h want 00", rdata); end
    tick(); // edge 2: s2 = A5
    n_tests++; if (rdata !== 8'hA5) begin n_fail++; $display("FAIL sync_edge2: got %h want a5", rdata); end
    addr = 8'd241; #1;
    n_tests++; if (rdata !== 8'h00) begin n_fail++; $display("FAIL flag_edge2: got %h want 00", rdata); end
    tick(); // edge 3: flag set
    n_tests++; if (rdata !== 8'h01) begin n_fail++; $display("FAIL flag_edge3: got %h want 01", rdata); end
    n_tests++; if (irq !== 1'b0) begin n_fail++; $display("FAIL irq_masked: got %b want 0", irq); end
    for (int c = 0; c < 4; c++) bus_write(8'(241 + 2*c), 8'h01);
    addr = 8'd247; #1;
    n_tests++; if (rdata !== 8'h00) begin n_fail++; $display("FAIL flag_clear_ch3: got %h want 00", rdata); end
  endtask

  task automatic test_output_write;
    addr = 8'd242; wdata = 8'h3C; we = 1'b1; #1;
    n_tests++; if (mem_we !== 1'b0 || hit !== 1'b1) begin n_fail++; $display("FAIL io_write_decode: got mem_we=%b hit=%b want 0/1", mem_we, hit); end
    n_tests++; if (port_out !== 32'h0) begin n_fail++; $display("FAIL io_write_early: got %h want 0", port_out); end
    tick(); we = 1'b0;
    n_tests++; if (port_out !== 32'h0000_3C00) begin n_fail++; $display("FAIL io_write: got %h want 00003c00", port_out); end
    addr = 8'd100; wdata = 8'h55; we = 1'b1; #1;
    n_tests++; if (mem_we !== 1'b1 || hit !== 1'b0) begin n_fail++; $display("FAIL mem_write_decode: got mem_we=%b hit=%b want 1/0", mem_we, hit); end
    tick(); we = 1'b0;
    n_tests++; if (port_out !== 32'h0000_3C00) begin n_fail++; $display("FAIL mem_write_no_io: got %h want 00003c00", port_out); end
  endtask

  task automatic test_read_mux;
    mem_rdata = 8'h77;
    bus_write(8'd247, 8'h02);
    addr = 8'd247; #1;
    n_tests++; if (rdata !== 8'h02) begin n_fail++; $display("FAIL read_ctrl_ch3: got %h want 02", rdata); end
    addr = 8'd248; #1;
    n_tests++; if (rdata !== 8'h77 || hit !== 1'b0) begin n_fail++; $display("FAIL read_above: got %h hit=%b want 77/0", rdata, hit); end
    addr = 8'd239; #1;
    n_tests++; if (rdata !== 8'h77 || hit !== 1'b0) begin n_fail++; $display("FAIL read_below: got %h hit=%b want 77/0", rdata, hit); end
    addr = 8'd246; #1;
    n_tests++; if (rdata !== 8'hA5) begin n_fail++; $display("FAIL read_data_ch3: got %h want a5", rdata); end
    n_tests++; if (mem_we !== 1'b0) begin n_fail++; $display("FAIL mem_we_idle: got %b want 0", mem_we); end
  endtask

  task automatic test_change_irq;
    bus_write(8'd245, 8'h02);
    set_port(2, 8'h00);
    tick(); tick(); tick();
    bus_write(8'd245, 8'h03);
    n_tests++; if (irq !== 1'b0) begin n_fail++; $display("FAIL irq_prearm: got %b want 0", irq); end
    set_port(2, 8'h01);
    tick(); // k
    n_tests++; if (irq !== 1'b0) begin n_fail++; $display("FAIL irq_k: got %b want 0", irq); end
    tick(); // k+1
    addr = 8'd244; #1;
    n_tests++; if (rdata !== 8'h01 || irq !== 1'b0) begin n_fail++; $display("FAIL chg_k1: got data=%h irq=%b want 01/0", rdata, irq); end
    tick(); // k+2
    addr = 8'd245; #1;
    n_tests++; if (rdata !== 8'h03 || irq !== 1'b1) begin n_fail++; $display("FAIL chg_k2: got ctrl=%h irq=%b want 03/1", rdata, irq); end
    bus_write(8'd245, 8'h02);
    addr = 8'd245; #1;
    n_tests++; if (rdata !== 8'h03 || irq !== 1'b1) begin n_fail++; $display("FAIL ctrl_noclear: got ctrl=%h irq=%b want 03/1", rdata, irq); end
    bus_write(8'd245, 8'h03);
    addr = 8'd245; #1;
    n_tests++; if (rdata !== 8'h02 || irq !== 1'b0) begin n_fail++; $display("FAIL ctrl_clear: got ctrl=%h irq=%b want 02/0", rdata, irq); end
  endtask

  task automatic test_race;
    set_port(0, 8'h5A);
    tick(); tick();  // edges k, k+1
    bus_write(8'd241, 8'h01);  // clear lands on k+2, same edge as the set
    addr = 8'd241; #1;
    n_tests++; if (rdata !== 8'h01) begin n_fail++; $display("FAIL race_set_wins: got %h want 01", rdata); end
    bus_write(8'd241, 8'h01);
    addr = 8'd241; #1;
    n_tests++; if (rdata !== 8'h00) begin n_fail++; $display("FAIL race_later_clear: got %h want 00", rdata); end
  endtask

  task automatic test_back_to_back;
    addr = 8'd240; wdata = 8'h11; we = 1'b1;
    tick();
    addr = 8'd246; wdata = 8'h99;
    tick();
    we = 1'b0;
    n_tests++; if (port_out !== 32'h9900_3C11) begin n_fail++; $display("FAIL back_to_back: got %h want 99003c11", port_out); end
  endtask

  task automatic test_async_reset;
    set_port(0, 8'h11);
    tick(); tick(); tick();
    bus_write(8'd241, 8'h02);
    n_tests++; if (irq !== 1'b1) begin n_fail++; $display("FAIL pre_reset_irq: got %b want 1", irq); end
    #2 reset = 1'b1;
    addr = 8'd241; #1;
    n_tests++; if (port_out !== 32'h0 || irq !== 1'b0 || rdata !== 8'h00) begin
      n_fail++; $display("FAIL async_reset: got port_out=%h irq=%b ctrl=%h want 0/0/00", port_out, irq, rdata);
    end
    @(negedge clk);
    reset = 1'b0;
    addr = 8'd240;
    tick(); tick();
    n_tests++; if (rdata !== 8'h11) begin n_fail++; $display("FAIL post_reset_sync: got %h want 11", rdata); end
  endtask

  initial begin
    test_reset();
    test_output_write();
    test_read_mux();
    test_change_irq();
    test_race();
    test_back_to_back();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/mmio_port_bank.md
Name: mmio_port_bank

Overview:
- Parametrised memory-mapped I/O bank between the processor data bus and data memory.
- Replaces the single hard-wired I/O address with a window of NUM_PORTS channels.
- Each channel has an output latch, a two-flop synchroniser on its input, a sticky change flag and a maskable interrupt.
- Owns the read-data mux (I/O vs memory) and suppresses memory writes that hit the I/O window.

Parameters:
DATA_WIDTH, 8, data bus and per-channel port width.
ADDR_WIDTH, 8, bus address width.
NUM_PORTS, 4, channel count (1..16).
BASE_ADDR, 240, first address of the I/O window. Constraint: BASE_ADDR + 2*NUM_PORTS <= 2**ADDR_WIDTH, and BASE_ADDR is even.

Ports:
clk  input  1  system clock, rising edge.
reset  input  1  asynchronous, active-high reset.
addr  input  ADDR_WIDTH  bus address (ALU result).
wdata  input  DATA_WIDTH  bus write data.
we  input  1  bus write strobe.
mem_rdata  input  DATA_WIDTH  data-memory read data.
rdata  output  DATA_WIDTH  read data returned to the core.
mem_we  output  1  write enable forwarded to data memory.
hit  output  1  addr falls inside the I/O window.
port_in  input  NUM_PORTS*DATA_WIDTH  external inputs; channel i at bits [i*DATA_WIDTH +: DATA_WIDTH]; asynchronous to clk.
port_out  output  NUM_PORTS*DATA_WIDTH  registered external outputs, same packing.
irq  output  1  OR of enabled change flags.

Behaviour:
- Clocking/reset: single clock, clk. Reset is asynchronous, active-high. While reset is high: port_out=0, both sync stages=0, previous-sample register=0, flags=0, irq enables=0. irq is therefore 0.
- Decode (combinational): hit = (addr >= BASE_ADDR) && (addr < BASE_ADDR + 2*NUM_PORTS). off = addr - BASE_ADDR; ch = off>>1; sel = off[0].
- Register map, channel ch:
  - sel=0 DATA. Read returns sync stage 2 of port_in[ch]. Write loads port_out[ch].
  - sel=1 CTRL. Read returns {0.., ien[ch], flag[ch]} (bit0 flag, bit1 ien, upper bits 0). Write: bit1 -> ien[ch]; bit0=1 clears flag[ch]; bit0=0 has no effect on the flag.
- Writes: commit at the rising edge where we && hit. port_out is visible the cycle after that edge (1-cycle latency). A write without hit leaves all bank state unchanged.
- mem_we = we && !hit (combinational). Memory never sees I/O writes.
- rdata = hit ? io_read : mem_rdata (combinational, no read side effects; reads never clear flags).
- Synchroniser per channel: s1 <= port_in; s2 <= s1; prev <= s2, every edge.
- Change detect: flag[ch] is set at the edge where (s2 != prev), sticky until cleared.
  - Latency: port_in changes before edge k -> s1 at k, s2 at k+1, flag=1 after edge k+2. DATA read shows the new value from edge k+1.
- Simultaneous set and CTRL clear on the same edge: set wins, flag stays 1.
- irq = |(flag & ien), combinational from registers. Enabling ien while a flag is already set raises irq immediately after the write edge.
- Bus/port width is exactly DATA_WIDTH. No truncation or extension except CTRL read zero-fill.
- Reset asserted mid-operation clears everything immediately (asynchronous). The first edge after deassertion samples normally. Going from reset 0s to a non-zero input produces a flag per the change-detect rule.
- All addresses inside the window map to a register; no holes, no error response.

Test Plan:
- Reset: hold reset with port_in = 0xA5 on all channels -> port_out=0, irq=0, CTRL reads 0x00. Release -> DATA read of ch0 (addr 240) is 0xA5 after 2 edges, and flag ch0 sets after edge 3.
- Output write: we=1, addr=242, wdata=0x3C -> port_out ch1=0x3C the next cycle, mem_we=0, other channels unchanged. Same write to addr 100 -> mem_we=1, port_out unchanged.
- Read mux: addr=247 -> rdata=CTRL ch3. addr=248 -> rdata=mem_rdata (e.g. 0x77). addr=239 -> mem_rdata.
- Change/irq: write 0x02 to addr 245 (ien ch2); toggle port_in ch2 0x00->0x01 -> flag ch2=1 and irq=1 exactly 3 edges later. Write 0x03 to 245 -> flag clears, irq=0, ien stays 1.
- Set-vs-clear race: arrange change detection on the same edge as a CTRL write of 0x01 to ch0 -> flag remains 1.
- Async reset mid-run: assert reset between edges with port_out ch1=0x3C and flags set -> port_out, flags and irq go to 0 before the next clk edge.
